// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: N-input output-port arbiter with wormhole lock.
// Optional lock timeout when ARB_LOCK_TIMEOUT_EN is defined.
module noc_rr_arbiter #(
  parameter  int N_PORTS   = 5,
  parameter  int PRIO_MODE = 0,
  parameter  int MAX_HOLD  = 64,
  localparam int IDXW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] tail,
  input  logic               xfer,
  output logic [N_PORTS-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDXW-1:0]    gnt_idx,
  output logic               timeout_evt
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [N_PORTS-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic               vld_q;

  logic               locked;
  logic               rel;
  logic               to_rel;
  logic [IDXW-1:0]    nxt_ptr;
  logic [IDXW-1:0]    arb_ptr;
  logic [IDXW-1:0]    win;
  logic               found;
  logic [IDXW:0]      cand;
  logic [IDXW-1:0]    c;

  if (N_PORTS < 2 || MAX_HOLD < 2) begin : g_bad_cfg
    $error("noc_rr_arbiter: N_PORTS and MAX_HOLD must be >= 2");
  end

  assign locked  = (state_q == LOCKED);
  assign nxt_ptr = (idx_q == IDXW'(N_PORTS-1)) ? '0 : idx_q + 1'b1;

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_q;

  assign to_rel = locked && !xfer && (hold_q == HW'(MAX_HOLD-1));

  // Hold counter: clears on lock entry/release and on progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
    end else if (locked && !rel && !xfer) begin
      hold_q <= hold_q + 1'b1;
    end else begin
      hold_q <= '0;
    end
  end
`else
  assign to_rel = 1'b0;
`endif

  assign timeout_evt = to_rel;
  assign rel     = locked && ((xfer && tail[idx_q]) || to_rel);
  assign arb_ptr = rel ? nxt_ptr : ptr_q;

  // Winner pick: releasing port is last in RR order via arb_ptr
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    c     = '0;
    if (PRIO_MODE == 1) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (!found && req[i]) begin
          found = 1'b1;
          win   = IDXW'(i);
        end
      end
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        cand = {1'b0, arb_ptr} + (IDXW+1)'(i);
        if (cand >= (IDXW+1)'(N_PORTS))
          cand = cand - (IDXW+1)'(N_PORTS);
        c = cand[IDXW-1:0];
        if (!found && req[c]) begin
          found = 1'b1;
          win   = c;
        end
      end
    end
  end

  // Next-state: grant on request, freeze while locked, re-arb on release
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCKED;
          gnt_d   = N_PORTS'(1) << win;
          idx_d   = win;
        end
      end
      LOCKED: begin
        if (rel) begin
          ptr_d = nxt_ptr;
          if (found) begin
            gnt_d = N_PORTS'(1) << win;
            idx_d = win;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered grant state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      vld_q   <= |gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// tb_noc_rr_arbiter: directed checks for noc_rr_arbiter.
// Two instances: round-robin and fixed priority, shared stimulus.
module tb_noc_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       xfer;

  logic [4:0] rr_gnt, fx_gnt;
  logic       rr_vld, fx_vld;
  logic [2:0] rr_idx, fx_idx;
  logic       rr_to, fx_to;

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  noc_rr_arbiter #(.N_PORTS(5), .PRIO_MODE(0), .MAX_HOLD(8)) u_rr (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .xfer(xfer),
    .gnt(rr_gnt), .gnt_valid(rr_vld), .gnt_idx(rr_idx),
    .timeout_evt(rr_to)
  );

  noc_rr_arbiter #(.N_PORTS(5), .PRIO_MODE(1), .MAX_HOLD(8)) u_fx (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .xfer(xfer),
    .gnt(fx_gnt), .gnt_valid(fx_vld), .gnt_idx(fx_idx),
    .timeout_evt(fx_to)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rr(input string tag, input logic [4:0] g,
                        input logic [2:0] i);
    chk({tag, "_gnt"}, 32'(rr_gnt), 32'(g));
    chk({tag, "_idx"}, 32'(rr_idx), 32'(i));
    chk({tag, "_vld"}, 32'(rr_vld), 32'(|g));
  endtask

  logic [4:0] t2_g [6];
  logic [2:0] t2_i [6];

  initial begin
    t2_g = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    t2_i = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    // T1 reset
    rst = 1'b0; req = 5'b11111; tail = '0; xfer = 1'b0;
    tick(); tick();
    chk_rr("t1_rst", 5'b00000, 3'd0);
    chk("t1_rst_to", 32'(rr_to), 32'd0);
    #2 rst = 1'b1;
    tick();
    chk_rr("t1_first", 5'b00001, 3'd0);
    chk("t1_fx", 32'(fx_gnt), 32'h01);

    // T2 round-robin rotation, no bubbles
    tail = 5'b11111; xfer = 1'b1;
    for (int k = 1; k < 6; k++) begin
      tick();
      chk_rr($sformatf("t2_c%0d", k), t2_g[k], t2_i[k]);
    end
    req = '0;
    tick();
    chk_rr("t2_idle", 5'b00000, 3'd0);
    chk("t2_fx_idle", 32'(fx_vld), 32'd0);

    // T3 wormhole lock on port 2, stalls, port 0 waiting
    req = 5'b00100; tail = '0; xfer = 1'b0;
    tick();
    chk_rr("t3_grant", 5'b00100, 3'd2);
    req = 5'b00101; xfer = 1'b1;
    tick(); tick();
    chk_rr("t3_body", 5'b00100, 3'd2);
    xfer = 1'b0;
    tick();
    req = 5'b00001;
    tick();
    req = 5'b00101; tail = 5'b00100;
    tick();
    chk_rr("t3_stall", 5'b00100, 3'd2);
    tail = '0; xfer = 1'b1;
    tick();
    chk_rr("t3_f3", 5'b00100, 3'd2);
    tail = 5'b00100;
    tick();
    chk_rr("t3_next", 5'b00001, 3'd0);
    req = '0; tail = 5'b11111;
    tick();
    chk_rr("t3_idle", 5'b00000, 3'd0);

    // T4 fixed priority vs round-robin
    req = 5'b11000; tail = '0; xfer = 1'b0;
    tick();
    chk("t4_fx_g", 32'(fx_gnt), 32'h08);
    chk("t4_rr_g", 32'(rr_gnt), 32'h08);
    req = 5'b11010;
    tick(); tick();
    chk("t4_fx_hold", 32'(fx_gnt), 32'h08);
    tail = 5'b01000; xfer = 1'b1;
    tick();
    chk("t4_fx_next", 32'(fx_gnt), 32'h02);
    chk("t4_fx_idx", 32'(fx_idx), 32'd1);
    chk_rr("t4_rr_next", 5'b10000, 3'd4);
    req = '0; tail = 5'b11111;
    tick();
    chk("t4_fx_idle", 32'(fx_gnt), 32'h00);
    chk_rr("t4_rr_idle", 5'b00000, 3'd0);

    // T5 lock timeout
    req = 5'b01000; tail = '0; xfer = 1'b0;
    tick();
    chk_rr("t5_lock", 5'b01000, 3'd3);
    chk("t5_to_c1", 32'(rr_to), 32'd0);
    req = 5'b01001;
    for (int k = 2; k < 8; k++) tick();
    chk("t5_to_c7", 32'(rr_to), 32'd0);
    chk_rr("t5_c7", 5'b01000, 3'd3);
    tick();
`ifdef ARB_LOCK_TIMEOUT_EN
    chk("t5_to_c8", 32'(rr_to), 32'd1);
    chk_rr("t5_c8", 5'b01000, 3'd3);
    tick();
    chk("t5_to_c9", 32'(rr_to), 32'd0);
    chk_rr("t5_moved", 5'b00001, 3'd0);
`else
    chk("t5_to_c8", 32'(rr_to), 32'd0);
    tick();
    chk("t5_to_c9", 32'(rr_to), 32'd0);
    chk_rr("t5_held", 5'b01000, 3'd3);
`endif

    // T6 async reset mid-packet
    #3 rst = 1'b0;
    #1;
    chk_rr("t6_rst", 5'b00000, 3'd0);
    chk("t6_fx_rst", 32'(fx_gnt), 32'h00);
    #1 rst = 1'b1; req = 5'b00010; xfer = 1'b0; tail = '0;
    tick();
    chk_rr("t6_after", 5'b00010, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
